// File: rtl/cpu_ctrl_fsm_gen.sv
// Multi-cycle control unit for the 16-bit CPU: RST/FETCH/DECODE/EXEC/MEMWAIT/HALT sequencing,
// datapath strobes, registered Z/C flags, memory handshake with timeout, illegal-opcode detect.
module cpu_ctrl_fsm_gen #(
  parameter int OPC_W    = 4,
  parameter int ALU_OP_W = 4,
  parameter int TMO_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                Z,
  input  logic                C,
  input  logic                mem_ready,
  output logic                Load_IR,
  output logic                Inc_PC,
  output logic                Load_PC,
  output logic                Load_A,
  output logic                Load_B,
  output logic                Load_C,
  output logic                wen_DM,
  output logic                Sel2,
  output logic                mem_req,
  output logic [ALU_OP_W-1:0] opcode_ALU,
  output logic [1:0]          alu_mode,
  output logic                z_flag,
  output logic                c_flag,
  output logic                halted,
  output logic                err_illegal,
  output logic                err_timeout
);

  typedef enum logic [2:0] {
    S_RST     = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEMWAIT = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b0100;
  localparam logic [3:0] OP_LDA = 4'b0101;
  localparam logic [3:0] OP_LDB = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1010;
  localparam logic [3:0] OP_JZ  = 4'b1011;
  localparam logic [3:0] OP_JC  = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_LOGIC = 2'b01;
  localparam logic [1:0] MODE_IDLE  = 2'b11;

  // Last count value before timeout: the (2**TMO_W-1)th MEMWAIT cycle sees this value.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state, state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             cnt_clr, cnt_inc, tmo_set;
  logic             flag_ld, z_nxt, c_nxt;

  // Opcode decode; any nonzero bit above the low nibble makes the encoding illegal.
  logic [3:0] op4;
  logic       op_hi_zero;
  logic       is_add, is_sub, is_and, is_ldi, is_st, is_lda, is_ldb;
  logic       is_jmp, is_jz, is_jc, is_nop, is_hlt, is_mem;

  assign op4        = opcode[3:0];
  assign op_hi_zero = ((opcode >> 4) == '0);
  assign is_add     = op_hi_zero && (op4 == OP_ADD);
  assign is_sub     = op_hi_zero && (op4 == OP_SUB);
  assign is_and     = op_hi_zero && (op4 == OP_AND);
  assign is_ldi     = op_hi_zero && (op4 == OP_LDI);
  assign is_st      = op_hi_zero && (op4 == OP_ST);
  assign is_lda     = op_hi_zero && (op4 == OP_LDA);
  assign is_ldb     = op_hi_zero && (op4 == OP_LDB);
  assign is_jmp     = op_hi_zero && (op4 == OP_JMP);
  assign is_jz      = op_hi_zero && (op4 == OP_JZ);
  assign is_jc      = op_hi_zero && (op4 == OP_JC);
  assign is_nop     = op_hi_zero && (op4 == OP_NOP);
  assign is_hlt     = op_hi_zero && (op4 == OP_HLT);
  assign is_mem     = is_st || is_lda || is_ldb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_RST;
      tmo_cnt     <= '0;
      z_flag      <= 1'b0;
      c_flag      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)      tmo_cnt <= '0;
      else if (cnt_inc) tmo_cnt <= tmo_cnt + 1'b1;
      if (flag_ld) begin
        z_flag <= z_nxt;
        c_flag <= c_nxt;
      end
      if (tmo_set) err_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    Load_IR     = 1'b0;
    Inc_PC      = 1'b0;
    Load_PC     = 1'b0;
    Load_A      = 1'b0;
    Load_B      = 1'b0;
    Load_C      = 1'b0;
    wen_DM      = 1'b0;
    Sel2        = 1'b0;
    mem_req     = 1'b0;
    opcode_ALU  = '0;
    alu_mode    = MODE_IDLE;
    halted      = 1'b0;
    err_illegal = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    tmo_set     = 1'b0;
    flag_ld     = 1'b0;
    z_nxt       = z_flag;
    c_nxt       = c_flag;

    case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH: begin
        Load_IR   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = is_hlt ? S_HALT : S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        if (is_add || is_sub) begin
          opcode_ALU = ALU_OP_W'(op4);
          alu_mode   = MODE_ARITH;
          Load_C     = 1'b1;
          Inc_PC     = 1'b1;
          flag_ld    = 1'b1;
          z_nxt      = Z;
          c_nxt      = C;
        end else if (is_and) begin
          opcode_ALU = ALU_OP_W'(OP_AND);
          alu_mode   = MODE_LOGIC;
          Load_C     = 1'b1;
          Inc_PC     = 1'b1;
          flag_ld    = 1'b1;
          z_nxt      = Z;
          c_nxt      = 1'b0;
        end else if (is_ldi) begin
          Load_C = 1'b1;
          Inc_PC = 1'b1;
        end else if (is_mem) begin
          // A memory that is already ready completes the access without entering MEMWAIT.
          Sel2    = 1'b1;
          mem_req = 1'b1;
          wen_DM  = is_st;
          cnt_clr = 1'b1;
          if (mem_ready) begin
            Load_A = is_lda;
            Load_B = is_ldb;
            Inc_PC = 1'b1;
          end else begin
            state_nxt = S_MEMWAIT;
          end
        end else if (is_jmp) begin
          Load_PC = 1'b1;
        end else if (is_jz) begin
          Load_PC = z_flag;
          Inc_PC  = ~z_flag;
        end else if (is_jc) begin
          Load_PC = c_flag;
          Inc_PC  = ~c_flag;
        end else if (is_nop) begin
          Inc_PC = 1'b1;
        end else begin
          Inc_PC      = 1'b1;
          err_illegal = 1'b1;
        end
      end
      S_MEMWAIT: begin
        Sel2    = 1'b1;
        mem_req = 1'b1;
        wen_DM  = is_st;
        if (mem_ready) begin
          Load_A    = is_lda;
          Load_B    = is_ldb;
          Inc_PC    = 1'b1;
          state_nxt = S_FETCH;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_set   = 1'b1;
          state_nxt = S_HALT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_HALT:  halted = 1'b1;
      default: state_nxt = S_RST;
    endcase
  end

  a_pc_excl: assert property (@(posedge clk) disable iff (!reset) !(Load_PC && Inc_PC));
  a_wen_req: assert property (@(posedge clk) disable iff (!reset) wen_DM |-> mem_req);

endmodule

// File: tb/tb_cpu_ctrl_fsm_gen.sv
// Directed bench for cpu_ctrl_fsm_gen: stimulus pushes per-cycle expected outputs into a
// scoreboard queue; a negedge monitor pops and compares against the DUT outputs.
module tb_cpu_ctrl_fsm_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       Z, C, mem_ready;
  logic       Load_IR, Inc_PC, Load_PC, Load_A, Load_B, Load_C, wen_DM, Sel2, mem_req;
  logic [3:0] opcode_ALU;
  logic [1:0] alu_mode;
  logic       z_flag, c_flag, halted, err_illegal, err_timeout;

  cpu_ctrl_fsm_gen #(.OPC_W(4), .ALU_OP_W(4), .TMO_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .Z(Z), .C(C), .mem_ready(mem_ready),
    .Load_IR(Load_IR), .Inc_PC(Inc_PC), .Load_PC(Load_PC), .Load_A(Load_A), .Load_B(Load_B),
    .Load_C(Load_C), .wen_DM(wen_DM), .Sel2(Sel2), .mem_req(mem_req),
    .opcode_ALU(opcode_ALU), .alu_mode(alu_mode), .z_flag(z_flag), .c_flag(c_flag),
    .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] s;
    logic [3:0] aop;
    logic [1:0] md;
    logic       z, c, h, ei, et;
  } vec_t;

  // Strobe bits: {Load_IR, Inc_PC, Load_PC, Load_A, Load_B, Load_C, wen_DM, Sel2, mem_req}
  localparam logic [8:0] IDLE = 9'h000, IR = 9'h100, INC = 9'h080, LPC = 9'h040;
  localparam logic [8:0] LA = 9'h020, LB = 9'h010, LC = 9'h008, WEN = 9'h004, SEL = 9'h002, MREQ = 9'h001;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    zf, cf, et;
  vec_t  act, m_e;
  string m_n;

  assign act = {Load_IR, Inc_PC, Load_PC, Load_A, Load_B, Load_C, wen_DM, Sel2, mem_req,
                opcode_ALU, alu_mode, z_flag, c_flag, halted, err_illegal, err_timeout};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      m_n = name_q.pop_front();
      n_tests++;
      if (act !== m_e) begin
        n_fail++;
        $display("FAIL %s: got strb=%h aop=%h mode=%b z=%b c=%b h=%b ei=%b et=%b, expected strb=%h aop=%h mode=%b z=%b c=%b h=%b ei=%b et=%b",
                 m_n, act.s, act.aop, act.md, act.z, act.c, act.h, act.ei, act.et,
                 m_e.s, m_e.aop, m_e.md, m_e.z, m_e.c, m_e.h, m_e.ei, m_e.et);
      end
    end
  end

  // Inputs for the current cycle are already driven; queue what the DUT must show this cycle.
  task automatic step(input string n, input logic [8:0] s, input logic [3:0] aop = 4'h0,
                      input logic [1:0] md = 2'b11, input bit h = 1'b0, input bit ei = 1'b0);
    vec_t e;
    e.s = s; e.aop = aop; e.md = md;
    e.z = zf; e.c = cf; e.h = h; e.ei = ei; e.et = et;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk); #1;
  endtask

  task automatic fd(input logic [3:0] op);
    opcode = op;
    step($sformatf("fetch_%h", op), IR);
    step($sformatf("decode_%h", op), IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    n_fail++;
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; opcode = 4'h4; Z = 1'b0; C = 1'b0; mem_ready = 1'b0;
    zf = 1'b0; cf = 1'b0; et = 1'b0;
    @(posedge clk); #1;
    step("rst_hold", IDLE);
    step("rst_hold2", IDLE);
    reset = 1'b1;
    step("rst_rel", IDLE);

    // LDI, period 3
    fd(4'h4); step("ldi_exec", LC | INC);
    fd(4'h4); step("ldi_exec2", LC | INC);

    // Arithmetic / logic flags and conditional jumps
    fd(4'h1); Z = 1'b1; C = 1'b1; step("add_exec", LC | INC, 4'h1, 2'b00);
    zf = 1'b1; cf = 1'b1; Z = 1'b0; C = 1'b0;
    fd(4'hB); step("jz_taken", LPC);
    fd(4'hC); step("jc_taken", LPC);
    fd(4'h8); step("sub_exec", LC | INC, 4'h8, 2'b00);
    zf = 1'b0; cf = 1'b0;
    fd(4'hB); step("jz_not", INC);
    fd(4'hC); step("jc_not", INC);
    fd(4'h9); Z = 1'b1; C = 1'b1; step("and_exec", LC | INC, 4'h9, 2'b01);
    zf = 1'b1; cf = 1'b0; Z = 1'b0; C = 1'b0;
    fd(4'hB); step("jz_after_and", LPC);
    fd(4'hC); step("jc_after_and", INC);
    fd(4'hA); step("jmp", LPC);
    fd(4'h0); step("nop", INC);

    // Illegal encodings: pulse, PC advances, flags untouched
    fd(4'h7); Z = 1'b0; C = 1'b1; step("illegal_7", INC, 4'h0, 2'b11, 1'b0, 1'b1);
    fd(4'hD); step("illegal_d", INC, 4'h0, 2'b11, 1'b0, 1'b1);
    Z = 1'b0; C = 1'b0;

    // Memory ops
    fd(4'h5); mem_ready = 1'b0;
    step("lda_exec", SEL | MREQ);
    step("lda_wait1", SEL | MREQ);
    step("lda_wait2", SEL | MREQ);
    mem_ready = 1'b1; step("lda_ready", SEL | MREQ | LA | INC);
    mem_ready = 1'b0;
    fd(4'h6); mem_ready = 1'b1; step("ldb_fast", SEL | MREQ | LB | INC);
    mem_ready = 1'b0;
    fd(4'h3); step("st_exec", SEL | MREQ | WEN);
    mem_ready = 1'b1; step("st_ready", SEL | MREQ | WEN | INC);
    mem_ready = 1'b0;

    // Reset in the middle of MEMWAIT
    fd(4'h5); step("lda6_exec", SEL | MREQ); step("lda6_wait", SEL | MREQ);
    reset = 1'b0; zf = 1'b0; cf = 1'b0;
    step("rst_mid_wait", IDLE);
    step("rst_mid_hold", IDLE);
    reset = 1'b1;
    step("rst_rel2", IDLE);

    // Store timeout into HALT
    fd(4'h1); Z = 1'b1; C = 1'b1; step("add2_exec", LC | INC, 4'h1, 2'b00);
    zf = 1'b1; cf = 1'b1; Z = 1'b0; C = 1'b0;
    fd(4'h3); step("st_tmo_exec", SEL | MREQ | WEN);
    for (int i = 1; i <= 15; i++) step($sformatf("st_wait%0d", i), SEL | MREQ | WEN);
    et = 1'b1; opcode = 4'h1;
    step("halt_tmo1", IDLE, 4'h0, 2'b11, 1'b1);
    step("halt_tmo2", IDLE, 4'h0, 2'b11, 1'b1);
    mem_ready = 1'b1;
    step("halt_tmo3", IDLE, 4'h0, 2'b11, 1'b1);
    mem_ready = 1'b0;
    reset = 1'b0; zf = 1'b0; cf = 1'b0; et = 1'b0;
    step("rst_clear", IDLE);
    reset = 1'b1;
    step("rst_rel3", IDLE);

    // HALT opcode
    fd(4'hF);
    step("halt_op1", IDLE, 4'h0, 2'b11, 1'b1);
    step("halt_op2", IDLE, 4'h0, 2'b11, 1'b1);

    repeat (2) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
